// File: rtl/instruction_fetch.sv
// instruction_fetch: fetch unit with one outstanding memory read and a small instruction buffer
// Ports: I_clk/I_reset_n clock and async active-low reset; I_enable stalls fetch and pops;
//   I_branch/I_branch_target redirect the fetch PC and flush the buffer;
//   O_mem_req/O_mem_addr/I_mem_ack/I_mem_data instruction memory read handshake;
//   O_valid/O_instruction/O_pc/I_ready decoder-side buffer head.
// Macro FETCH_PREFETCH_EN: 2-entry buffer so a fetch can run while the decoder stalls;
//   undefined gives a 1-entry buffer.
module instruction_fetch #(
  parameter logic [15:0] RESET_PC = 16'h0000
) (
  input  logic        I_clk,
  input  logic        I_reset_n,
  input  logic        I_enable,
  input  logic        I_branch,
  input  logic [15:0] I_branch_target,
  output logic        O_mem_req,
  output logic [15:0] O_mem_addr,
  input  logic        I_mem_ack,
  input  logic [15:0] I_mem_data,
  output logic        O_valid,
  output logic [15:0] O_instruction,
  output logic [15:0] O_pc,
  input  logic        I_ready
);
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  localparam logic [1:0] DEP = 2'(DEPTH);
  typedef enum logic [1:0] {IDLE, REQ, DISCARD} state_t;
  state_t state_q, state_d;
  logic mem_req_q, mem_req_d;
  logic [15:0] mem_addr_q, mem_addr_d, pc_q, pc_d;
  // Entries packed {instruction, pc}; entry 0 is the head and the buffer shifts down on pop.
  logic [32*DEPTH-1:0] buf_q, buf_d;
  logic [DEPTH-1:0] vld_q, vld_d;
  logic [1:0] cnt, occ;
  logic ack, pop, push;
  assign ack = I_mem_ack && state_q != IDLE;
  assign pop = vld_q[0] && I_ready && I_enable;
  assign push = ack && state_q == REQ && !I_branch;
  // occ is the fill level once this cycle's pop has taken effect.
  always_comb begin
    cnt = '0;
    for (int i = 0; i < DEPTH; i++) cnt = cnt + 2'(vld_q[i]);
    occ = cnt - 2'(pop);
  end
  always_comb begin
    state_d = state_q;
    mem_req_d = mem_req_q;
    mem_addr_d = mem_addr_q;
    pc_d = I_branch ? I_branch_target : pc_q;
    case (state_q)
      IDLE: if (I_enable && !I_branch && occ < DEP) begin
        state_d = REQ;
        mem_req_d = 1'b1;
        mem_addr_d = pc_q;
      end
      REQ: if (ack) begin
        if (!I_branch) pc_d = pc_q + 16'd1;
        if (I_enable && !I_branch && occ + 2'd1 < DEP) mem_addr_d = pc_q + 16'd1;
        else begin
          state_d = IDLE;
          mem_req_d = 1'b0;
        end
      end else if (I_branch) state_d = DISCARD;
      DISCARD: if (ack) begin
        state_d = IDLE;
        mem_req_d = 1'b0;
      end
      default: begin
        state_d = IDLE;
        mem_req_d = 1'b0;
      end
    endcase
  end
  always_comb begin
    buf_d = pop ? buf_q >> 32 : buf_q;
    vld_d = pop ? vld_q >> 1 : vld_q;
    for (int i = 0; i < DEPTH; i++)
      if (push && occ == 2'(i)) begin
        buf_d[32*i +: 32] = {I_mem_data, mem_addr_q};
        vld_d[i] = 1'b1;
      end
    if (I_branch) vld_d = '0;
  end
  always_ff @(posedge I_clk or negedge I_reset_n)
    if (!I_reset_n) begin
      state_q <= IDLE;
      mem_req_q <= 1'b0;
      mem_addr_q <= RESET_PC;
      pc_q <= RESET_PC;
      buf_q <= {DEPTH{16'h0000, RESET_PC}};
      vld_q <= '0;
    end else begin
      state_q <= state_d;
      mem_req_q <= mem_req_d;
      mem_addr_q <= mem_addr_d;
      pc_q <= pc_d;
      buf_q <= buf_d;
      vld_q <= vld_d;
    end
  assign O_mem_req = mem_req_q;
  assign O_mem_addr = mem_addr_q;
  assign O_valid = vld_q[0];
  assign O_instruction = buf_q[31:16];
  assign O_pc = buf_q[15:0];
endmodule

// File: tb/tb_instruction_fetch.sv
// tb_instruction_fetch: scoreboard bench with a memory responder for instruction_fetch
module tb_instruction_fetch;
`ifdef FETCH_PREFETCH_EN
  localparam int DEPTH = 2;
`else
  localparam int DEPTH = 1;
`endif
  logic I_clk = 1'b0, I_reset_n = 1'b0, I_enable = 1'b0, I_branch = 1'b0, I_mem_ack = 1'b0, I_ready = 1'b0;
  logic [15:0] I_branch_target = '0, I_mem_data = '0;
  logic O_mem_req, O_valid;
  logic [15:0] O_mem_addr, O_instruction, O_pc;
  instruction_fetch #(.RESET_PC(16'h0000)) dut (
    .I_clk(I_clk), .I_reset_n(I_reset_n), .I_enable(I_enable), .I_branch(I_branch),
    .I_branch_target(I_branch_target), .O_mem_req(O_mem_req), .O_mem_addr(O_mem_addr),
    .I_mem_ack(I_mem_ack), .I_mem_data(I_mem_data), .O_valid(O_valid),
    .O_instruction(O_instruction), .O_pc(O_pc), .I_ready(I_ready)
  );
  always #5 I_clk = ~I_clk;
  int total = 0, passed = 0;
  logic [31:0] q[$];
  logic [15:0] reqs[$];
  logic [15:0] exp_pc, held, data;
  bit busy, discarding, prev_en, prev_br, cdata_en, ack;
  logic [15:0] cdata;
  int lat, wcnt;
  task automatic model_reset(input bit en);
    q.delete();
    reqs.delete();
    busy = 0;
    discarding = 0;
    exp_pc = 16'h0000;
    wcnt = 0;
    cdata_en = 0;
    prev_en = en;
    prev_br = 0;
  endtask
  task automatic do_reset(input bit en);
    I_reset_n = 1'b0;
    I_enable = 1'b0;
    I_ready = 1'b0;
    I_branch = 1'b0;
    I_branch_target = '0;
    I_mem_ack = 1'b0;
    I_mem_data = '0;
    repeat (2) @(negedge I_clk);
    model_reset(en);
    I_reset_n = 1'b1;
    I_enable = en;
  endtask
  // One cycle: check outputs against the scoreboard at the negedge, then answer the memory and drive inputs.
  task automatic step(input bit en, input bit rdy, input bit br, input logic [15:0] tgt);
    @(negedge I_clk);
    total++;
    if (O_valid !== (q.size() != 0)) $display("FAIL valid: got %b want %b", O_valid, q.size() != 0);
    else passed++;
    if (O_valid === 1'b1 && q.size() != 0) begin
      total++;
      if ({O_instruction, O_pc} !== q[0])
        $display("FAIL head: got instr %h pc %h want %h", O_instruction, O_pc, q[0]);
      else passed++;
    end
    if (busy) begin
      total++;
      if (O_mem_req !== 1'b1 || O_mem_addr !== held)
        $display("FAIL hold: got req %b addr %h want req 1 addr %h", O_mem_req, O_mem_addr, held);
      else passed++;
    end else if (O_mem_req === 1'b1) begin
      total++;
      if (O_mem_addr !== exp_pc || !prev_en || prev_br || q.size() >= DEPTH)
        $display("FAIL newreq: got addr %h en %b br %b buffered %0d want addr %h", O_mem_addr, prev_en, prev_br, q.size(), exp_pc);
      else passed++;
      busy = 1;
      held = O_mem_addr;
      wcnt = 0;
      reqs.push_back(O_mem_addr);
    end
    ack = busy && wcnt >= lat;
    if (busy) wcnt++;
    data = cdata_en ? cdata : (O_mem_addr ^ 16'hBEEF);
    I_enable = en;
    I_ready = rdy;
    I_branch = br;
    I_branch_target = tgt;
    I_mem_ack = ack;
    I_mem_data = data;
    if (q.size() != 0 && rdy && en) void'(q.pop_front());
    if (ack) begin
      busy = 0;
      if (!br && !discarding) begin
        q.push_back({data, held});
        exp_pc = held + 16'd1;
      end
      discarding = 0;
    end
    if (br) begin
      q.delete();
      exp_pc = tgt;
      if (busy) discarding = 1;
    end
    prev_en = en;
    prev_br = br;
  endtask
  task automatic test_reset;
    I_reset_n = 1'b0;
    @(negedge I_clk);
    total++;
    if (O_mem_req !== 1'b0 || O_valid !== 1'b0) $display("FAIL rst_flags: got req %b valid %b want 0 0", O_mem_req, O_valid);
    else passed++;
    total++;
    if (O_mem_addr !== 16'h0 || O_pc !== 16'h0 || O_instruction !== 16'h0)
      $display("FAIL rst_regs: got addr %h pc %h instr %h want 0000", O_mem_addr, O_pc, O_instruction);
    else passed++;
    do_reset(1);
    lat = 0;
    step(1, 1, 0, 16'h0);
    total++;
    if (reqs.size() != 1 || reqs[0] !== 16'h0000) $display("FAIL first_req: got %0d requests want 1 at 0000", reqs.size());
    else passed++;
  endtask
  task automatic test_stream;
    do_reset(1);
    lat = 0;
    cdata_en = 1;
    cdata = 16'h1234;
    step(1, 1, 0, 16'h0);
    step(1, 1, 0, 16'h0);
    total++;
    if (O_valid !== 1'b1 || O_instruction !== 16'h1234 || O_pc !== 16'h0000)
      $display("FAIL stream_first: got valid %b instr %h pc %h want 1 1234 0000", O_valid, O_instruction, O_pc);
    else passed++;
    repeat (20) step(1, 1, 0, 16'h0);
    total++;
    if (reqs.size() < 10 || reqs[reqs.size()-1] !== 16'(reqs.size() - 1))
      $display("FAIL stream_addrs: got %0d requests want at least 10 in sequence", reqs.size());
    else passed++;
  endtask
  task automatic test_backpressure;
    do_reset(1);
    lat = 0;
    repeat (8) step(1, 0, 0, 16'h0);
    total++;
    if (O_mem_req !== 1'b0 || O_valid !== 1'b1 || O_pc !== 16'h0000)
      $display("FAIL bp_state: got req %b valid %b pc %h want 0 1 0000", O_mem_req, O_valid, O_pc);
    else passed++;
    total++;
    if (reqs.size() != DEPTH) $display("FAIL bp_words: got %0d buffered words want %0d", reqs.size(), DEPTH);
    else passed++;
    repeat (10) step(1, 1, 0, 16'h0);
    total++;
    if (reqs.size() <= DEPTH + 2) $display("FAIL bp_resume: got %0d requests want more than %0d", reqs.size(), DEPTH + 2);
    else passed++;
  endtask
  task automatic test_wait;
    do_reset(1);
    lat = 3;
    step(1, 1, 0, 16'h0);
    for (int i = 0; i < 3; i++) begin
      step(1, 1, 0, 16'h0);
      total++;
      if (O_mem_req !== 1'b1 || O_mem_addr !== 16'h0000 || O_valid !== 1'b0)
        $display("FAIL wait_hold: got req %b addr %h valid %b want 1 0000 0", O_mem_req, O_mem_addr, O_valid);
      else passed++;
    end
    step(1, 0, 0, 16'h0);
    step(1, 0, 0, 16'h0);
    total++;
    if (O_valid !== 1'b1 || O_pc !== 16'h0000 || O_instruction !== 16'hBEEF)
      $display("FAIL wait_push: got valid %b pc %h instr %h want 1 0000 beef", O_valid, O_pc, O_instruction);
    else passed++;
    repeat (20) step(1, 1, 0, 16'h0);
  endtask
  task automatic test_branch;
    int n;
    do_reset(1);
    lat = 3;
    n = 0;
    while (!(busy && held == 16'h0005) && n < 100) begin
      step(1, 1, 0, 16'h0);
      n++;
    end
    step(1, 1, 1, 16'h0040);
    n = 0;
    while (O_valid !== 1'b1 && n < 30) begin
      step(1, 0, 0, 16'h0);
      n++;
    end
    total++;
    if (O_valid !== 1'b1 || O_pc !== 16'h0040 || O_instruction !== (16'h0040 ^ 16'hBEEF))
      $display("FAIL branch_target: got valid %b pc %h instr %h want 1 0040 %h", O_valid, O_pc, O_instruction, 16'h0040 ^ 16'hBEEF);
    else passed++;
    total++;
    if (reqs.size() != 7 || reqs[6] !== 16'h0040)
      $display("FAIL branch_reqs: got %0d requests want 7 ending at 0040", reqs.size());
    else passed++;
    repeat (6) step(1, 1, 0, 16'h0);
  endtask
  task automatic test_branch_on_ack;
    do_reset(1);
    lat = 0;
    step(1, 1, 1, 16'h0100);
    step(1, 1, 0, 16'h0);
    total++;
    if (O_valid !== 1'b0) $display("FAIL brack_drop: got valid %b want 0", O_valid);
    else passed++;
    repeat (4) step(1, 1, 0, 16'h0);
    total++;
    if (reqs.size() < 2 || reqs[1] !== 16'h0100) $display("FAIL brack_addr: got %0d requests want second at 0100", reqs.size());
    else passed++;
  endtask
  task automatic test_wrap;
    int n;
    do_reset(0);
    lat = 0;
    step(0, 1, 1, 16'hFFFF);
    n = 0;
    while (reqs.size() < 2 && n < 20) begin
      step(1, 1, 0, 16'h0);
      n++;
    end
    total++;
    if (reqs.size() < 2 || reqs[0] !== 16'hFFFF || reqs[1] !== 16'h0000)
      $display("FAIL wrap: got %0d requests want ffff then 0000", reqs.size());
    else passed++;
    repeat (4) step(1, 1, 0, 16'h0);
  endtask
  task automatic test_enable;
    do_reset(1);
    lat = 2;
    step(1, 1, 0, 16'h0);
    repeat (6) step(0, 1, 0, 16'h0);
    total++;
    if (O_valid !== 1'b1 || O_pc !== 16'h0000 || O_mem_req !== 1'b0 || reqs.size() != 1)
      $display("FAIL stall: got valid %b pc %h req %b requests %0d want 1 0000 0 1", O_valid, O_pc, O_mem_req, reqs.size());
    else passed++;
    repeat (12) step(1, 1, 0, 16'h0);
    total++;
    if (reqs.size() < 3) $display("FAIL stall_resume: got %0d requests want at least 3", reqs.size());
    else passed++;
  endtask
  task automatic test_async_reset;
    do_reset(1);
    lat = 0;
    repeat (4) step(1, 0, 0, 16'h0);
    total++;
    if (O_valid !== 1'b1) $display("FAIL arst_pre: got valid %b want 1", O_valid);
    else passed++;
    #2 I_reset_n = 1'b0;
    #1;
    total++;
    if (O_valid !== 1'b0 || O_instruction !== 16'h0000 || O_pc !== 16'h0000)
      $display("FAIL arst_buf: got valid %b instr %h pc %h want 0 0000 0000", O_valid, O_instruction, O_pc);
    else passed++;
    do_reset(1);
    lat = 5;
    step(1, 1, 0, 16'h0);
    #2 I_reset_n = 1'b0;
    #1;
    total++;
    if (O_mem_req !== 1'b0) $display("FAIL arst_req: got req %b want 0", O_mem_req);
    else passed++;
    I_enable = 1'b0;
    I_mem_ack = 1'b1;
    I_mem_data = 16'hDEAD;
    I_reset_n = 1'b1;
    repeat (2) @(negedge I_clk);
    total++;
    if (O_valid !== 1'b0 || O_mem_req !== 1'b0) $display("FAIL stale_ack: got valid %b req %b want 0 0", O_valid, O_mem_req);
    else passed++;
    model_reset(0);
    lat = 0;
    repeat (4) step(1, 1, 0, 16'h0);
    total++;
    if (reqs.size() < 1 || reqs[0] !== 16'h0000) $display("FAIL arst_restart: got %0d requests want first at 0000", reqs.size());
    else passed++;
  endtask
  initial begin
    model_reset(0);
    lat = 0;
    test_reset();
    test_stream();
    test_backpressure();
    test_wait();
    test_branch();
    test_branch_on_ack();
    test_wrap();
    test_enable();
    test_async_reset();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule

// File: doc/instruction_fetch.md
INSTRUCTION_FETCH -- requirements
Module: instruction_fetch

Interface
REQ-001 SHALL have parameter: RESET_PC, 16'h0000, word address of first fetch after reset.
REQ-002 SHALL have ports (name direction width meaning):
- I_clk  in  1  single clock, rising edge
- I_reset_n  in  1  asynchronous active-low reset
- I_enable  in  1  fetch enable; 0 = stall
- I_branch  in  1  redirect request
- I_branch_target  in  16  redirect word address
- O_mem_req  out  1  instruction memory read request
- O_mem_addr  out  16  memory word address
- I_mem_ack  in  1  read data valid
- I_mem_data  in  16  instruction word
- O_valid  out  1  instruction available to decoder
- O_instruction  out  16  instruction word to decoder
- O_pc  out  16  word address of O_instruction
- I_ready  in  1  decoder accepts O_instruction
REQ-003 SHALL have exactly one clock and one asynchronous active-low reset: I_clk and I_reset_n.

Function
REQ-004 SHALL implement FSM states IDLE, REQ, DISCARD; registered outputs only.
REQ-005 IDLE->REQ when I_enable=1, I_branch=0 and free buffer slots > 0; O_mem_req=1 and O_mem_addr=fetch PC from the next cycle.
REQ-006 In REQ, O_mem_req and O_mem_addr SHALL hold stable until the edge sampling I_mem_ack=1; at most one request outstanding.
REQ-007 On ack in REQ: push {I_mem_data, O_mem_addr} into buffer; fetch PC += 1, 16-bit wrap (16'hFFFF->16'h0000); go to IDLE, or stay in REQ with the new address if a slot remains after push and I_enable=1 and I_branch=0.
REQ-008 I_mem_ack outside REQ/DISCARD SHALL be ignored.
REQ-009 O_valid = buffer non-empty; O_instruction/O_pc = buffer head.
REQ-010 Pop when O_valid=1 and I_ready=1 and I_enable=1; simultaneous push and pop SHALL both take effect.
REQ-011 I_enable=0: no new request, no pop; an outstanding request SHALL still complete and its data SHALL be buffered.
REQ-012 I_branch=1 at an edge: flush buffer (O_valid=0 next cycle), fetch PC <= I_branch_target; branch overrides same-cycle ack push and pop.
REQ-013 Branch while REQ with no ack that cycle: go to DISCARD, holding O_mem_req/O_mem_addr; the ack ends DISCARD and its data SHALL be dropped; then IDLE.
REQ-014 Branch on the ack edge: ack data dropped, no DISCARD.
REQ-015 Best-case latency: request in cycle N acked in cycle N -> O_valid=1 in cycle N+1.

Reset
REQ-016 I_reset_n=0 SHALL asynchronously force: state IDLE, O_mem_req=0, O_mem_addr=RESET_PC, fetch PC=RESET_PC, buffer empty, O_valid=0, O_instruction=16'h0000, O_pc=RESET_PC.
REQ-017 Reset mid-request SHALL abandon it; a stale ack after reset release with O_mem_req=0 SHALL be ignored.
REQ-018 First request SHALL appear on the first edge after deassertion with I_enable=1.

Configuration
REQ-019 Macro FETCH_PREFETCH_EN defined: 2-entry buffer; a request SHALL be issued while one instruction waits for the decoder.
REQ-020 FETCH_PREFETCH_EN undefined: 1-entry buffer; no request while O_valid=1 unless popped that cycle; all other REQs unchanged.

Verification
REQ-021 Reset release, RESET_PC=0, enable=1, ready=1, zero-wait ack, data=16'h1234 -> O_mem_addr 0,1,2...; O_valid=1, O_instruction=16'h1234, O_pc=0 one cycle after first ack.
REQ-022 ready=0 with FETCH_PREFETCH_EN -> two words buffered, O_mem_req=0, O_pc=0 held; without macro -> one word buffered.
REQ-023 Ack delayed 3 cycles -> O_mem_req and O_mem_addr stable all 3 cycles; single push.
REQ-024 Branch to 16'h0040 while request to 16'h0005 pending -> DISCARD; ack data dropped; next request addr 16'h0040; O_valid=0 until its ack.
REQ-025 Fetch PC 16'hFFFF acked -> next O_mem_addr=16'h0000.
REQ-026 I_reset_n=0 mid-REQ -> O_mem_req=0 and O_valid=0 immediately, without clock edge.
